// File: rtl/stage_sequencer.sv
// Stage-token sequencer for the multi-cycle 5-stage MIPS datapath.
// One-hot registered stage enables, halt handling, per-stage watchdog and counters.
module stage_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_halt_req,
    input  logic [4:0]       i_stage_done,
    input  logic             i_mem_access,
    input  logic             i_reg_write,
    output logic [4:0]       o_stage_en,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_error,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic [2:0]       r_state;
    logic [4:0]       r_stage_en;
    logic             r_busy;
    logic             r_halted;
    logic             r_error;
    logic             r_halt_pend;
    logic             r_reg_wr;
    logic [TO_W-1:0]  r_wd;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_instr;

    logic [2:0] w_next;
    logic [4:0] w_next_en;
    logic       w_busy_st;
    logic       w_idle_st;
    logic       w_done;
    logic       w_go;
    logic       w_retire;
    logic       w_timeout;
    logic       w_latch;

    assign w_busy_st = (r_state >= S_FETCH) && (r_state <= S_WB);
    assign w_idle_st = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_go      = w_idle_st && i_start;
    assign w_timeout = w_busy_st && !w_done && (r_wd == TO_W'(TIMEOUT - 1));

    // Only the done bit of the active stage matters.
    always_comb begin
        w_done = 1'b0;
        case (r_state)
            S_FETCH:  w_done = i_stage_done[0];
            S_DECODE: w_done = i_stage_done[1];
            S_EXEC:   w_done = i_stage_done[2];
            S_MEM:    w_done = i_stage_done[3];
            S_WB:     w_done = i_stage_done[4];
            default:  w_done = 1'b0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        w_latch  = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: if (i_start) w_next = S_FETCH;
            S_FETCH:  if (w_done) w_next = S_DECODE;
            S_DECODE: if (w_done) w_next = S_EXEC;
            S_EXEC: begin
                if (w_done) begin
                    w_latch = 1'b1;
                    if (i_mem_access)     w_next = S_MEM;
                    else if (i_reg_write) w_next = S_WB;
                    else                  w_retire = 1'b1;
                end
            end
            S_MEM: begin
                if (w_done) begin
                    if (r_reg_wr) w_next = S_WB;
                    else          w_retire = 1'b1;
                end
            end
            S_WB:    if (w_done) w_retire = 1'b1;
            default: w_next = S_IDLE;
        endcase
        if (w_retire)
            w_next = (r_halt_pend || i_halt_req) ? S_HALT : S_FETCH;
        if (w_timeout)
            w_next = S_HALT;
    end

    always_comb begin
        w_next_en = 5'b00000;
        case (w_next)
            S_FETCH:  w_next_en = 5'b00001;
            S_DECODE: w_next_en = 5'b00010;
            S_EXEC:   w_next_en = 5'b00100;
            S_MEM:    w_next_en = 5'b01000;
            S_WB:     w_next_en = 5'b10000;
            default:  w_next_en = 5'b00000;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_stage_en  <= 5'b00000;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_error     <= 1'b0;
            r_halt_pend <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_wd        <= '0;
            r_cyc       <= '0;
            r_instr     <= '0;
        end else begin
            r_state    <= w_next;
            r_stage_en <= w_next_en;
            r_busy     <= (w_next >= S_FETCH) && (w_next <= S_WB);
            r_halted   <= (w_next == S_HALT);

            // mem_access is consumed at the EXECUTE edge; only reg_write is needed later.
            if (w_latch)
                r_reg_wr <= i_reg_write;

            if (w_next == S_HALT)
                r_halt_pend <= 1'b0;
            else if (w_busy_st && i_halt_req)
                r_halt_pend <= 1'b1;

            if (w_next != r_state)
                r_wd <= '0;
            else if (w_busy_st)
                r_wd <= r_wd + TO_W'(1);

            if (w_timeout)
                r_error <= 1'b1;
            else if (w_go)
                r_error <= 1'b0;

            if (r_busy)
                r_cyc <= r_cyc + CNT_W'(1);
            if (w_retire)
                r_instr <= r_instr + CNT_W'(1);
        end
    end

    assign o_stage_en    = r_stage_en;
    assign o_busy        = r_busy;
    assign o_halted      = r_halted;
    assign o_error       = r_error;
    assign o_cycle_count = r_cyc;
    assign o_instr_count = r_instr;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: an instruction-level model checked every
// cycle, plus hand-computed literal expectations along the directed scenarios.
module tb_stage_sequencer;
    localparam int CW   = 4;
    localparam int TO   = 4;
    localparam int MASK = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic [4:0]    done = 5'b0;
    logic          mem = 1'b0;
    logic          regw = 1'b0;
    logic [4:0]    en;
    logic          busy, halted, err;
    logic [CW-1:0] cyc, instr;

    int total = 0;
    int bad   = 0;

    stage_sequencer #(.CNT_W(CW), .TIMEOUT(TO), .TO_W(3)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_halt_req(halt),
        .i_stage_done(done), .i_mem_access(mem), .i_reg_write(regw),
        .o_stage_en(en), .o_busy(busy), .o_halted(halted), .o_error(err),
        .o_cycle_count(cyc), .o_instr_count(instr)
    );

    always #5 clk = ~clk;

    // Model: running flag, current stage 0..4, halted flag, counters.
    int m_run = 0, m_stage = 0, m_halt = 0, m_err = 0, m_pend = 0;
    int m_dwell = 0, m_reg = 0, m_cyc = 0, m_instr = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_run = 0; m_stage = 0; m_halt = 0; m_err = 0; m_pend = 0;
                m_dwell = 0; m_reg = 0; m_cyc = 0; m_instr = 0;
            end else if (m_run != 0) begin
                int fin;
                fin = 0;
                m_cyc = (m_cyc + 1) & MASK;
                if (done[m_stage]) begin
                    m_dwell = 0;
                    if (m_stage < 2) m_stage = m_stage + 1;
                    else if (m_stage == 2) begin
                        m_reg = int'(regw);
                        if (mem) m_stage = 3;
                        else if (regw) m_stage = 4;
                        else fin = 1;
                    end else if (m_stage == 3) begin
                        if (m_reg != 0) m_stage = 4;
                        else fin = 1;
                    end else fin = 1;
                    if (fin != 0) begin
                        m_instr = (m_instr + 1) & MASK;
                        m_stage = 0;
                        if (m_pend != 0 || halt) begin
                            m_run = 0; m_halt = 1; m_pend = 0;
                        end
                    end
                end else if (m_dwell == TO - 1) begin
                    m_err = 1; m_run = 0; m_halt = 1; m_pend = 0;
                end else begin
                    m_dwell = m_dwell + 1;
                end
                if (m_run != 0 && halt) m_pend = 1;
            end else if (start) begin
                m_run = 1; m_halt = 0; m_stage = 0; m_err = 0; m_dwell = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("m_stage_en", int'(en), (m_run != 0) ? (1 << m_stage) : 0);
            chk("m_busy",     int'(busy),   m_run);
            chk("m_halted",   int'(halted), m_halt);
            chk("m_error",    int'(err),    m_err);
            chk("m_cycles",   int'(cyc),    m_cyc);
            chk("m_instr",    int'(instr),  m_instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_en", int'(en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cyc", int'(cyc), 0);
        chk("rst_instr", int'(instr), 0);
        rst = 1'b0;
        tick();

        // Load with all done tied high, then halt during the next FETCH.
        done = 5'h1f; mem = 1'b1; regw = 1'b1; start = 1'b1;
        tick(); chk("load_c1", int'(en), 5'h01); start = 1'b0;
        tick(); chk("load_c2", int'(en), 5'h02);
        tick(); chk("load_c3", int'(en), 5'h04);
        tick(); chk("load_c4", int'(en), 5'h08);
        tick(); chk("load_c5", int'(en), 5'h10);
        tick(); chk("load_c6", int'(en), 5'h01); chk("load_instr", int'(instr), 1);
        halt = 1'b1; tick(); halt = 1'b0;
        repeat (4) tick();
        chk("load_halted", int'(halted), 1);
        chk("load_instr2", int'(instr), 2);
        chk("load_cyc", int'(cyc), 10);

        // Async reset in the middle of EXECUTE.
        done = 5'b00011; start = 1'b1;
        tick(); start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_en", int'(en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_cyc", int'(cyc), 0);
        chk("arst_instr", int'(instr), 0);
        chk("arst_err", int'(err), 0);
        tick(); rst = 1'b0; tick();

        // ALU then store, halt requested in the store's MEMORY cycle.
        done = 5'h1f; mem = 1'b0; regw = 1'b1; start = 1'b1;
        tick(); chk("alu_1", int'(en), 5'h01); start = 1'b0;
        tick(); chk("alu_2", int'(en), 5'h02);
        tick(); chk("alu_3", int'(en), 5'h04);
        tick(); chk("alu_4", int'(en), 5'h10);
        mem = 1'b1; regw = 1'b0;
        tick(); chk("st_1", int'(en), 5'h01);
        tick(); chk("st_2", int'(en), 5'h02);
        tick(); chk("st_3", int'(en), 5'h04);
        tick(); chk("st_4", int'(en), 5'h08);
        halt = 1'b1; tick(); halt = 1'b0;
        chk("as_halted", int'(halted), 1);
        chk("as_instr", int'(instr), 2);
        chk("as_cyc", int'(cyc), 8);

        // Branch with a one-cycle halt pulse in DECODE, then resume.
        mem = 1'b0; regw = 1'b0; start = 1'b1;
        tick(); chk("br_1", int'(en), 5'h01); start = 1'b0;
        tick(); chk("br_2", int'(en), 5'h02);
        halt = 1'b1; tick(); chk("br_3", int'(en), 5'h04); halt = 1'b0;
        tick(); chk("br_halted", int'(halted), 1); chk("br_instr", int'(instr), 3);
        start = 1'b1; tick(); chk("res_en", int'(en), 5'h01); chk("res_halted", int'(halted), 0);
        start = 1'b0;
        repeat (3) tick();
        chk("res_instr", int'(instr), 4); chk("res_en2", int'(en), 5'h01);

        // EXECUTE never completes: watchdog fires after 4 EXECUTE cycles.
        done = 5'b00011;
        tick(); chk("wd_dec", int'(en), 5'h02);
        tick(); chk("wd_ex1", int'(en), 5'h04);
        repeat (3) tick(); chk("wd_ex4", int'(en), 5'h04);
        tick();
        chk("wd_halted", int'(halted), 1);
        chk("wd_err", int'(err), 1);
        chk("wd_en", int'(en), 0);
        chk("wd_instr", int'(instr), 4);

        // Start clears error; inactive done bits are ignored in FETCH.
        done = 5'b11110; start = 1'b1;
        tick(); chk("clr_err", int'(err), 0); chk("inact_1", int'(en), 5'h01);
        start = 1'b0;
        tick(); chk("inact_2", int'(en), 5'h01);
        tick(); chk("inact_3", int'(en), 5'h01);

        // Counter wrap: 16 branch retires from reset.
        rst = 1'b1; tick(); rst = 1'b0;
        done = 5'h1f; mem = 1'b0; regw = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        repeat (45) tick();
        chk("wrap_15", int'(instr), 15);
        repeat (3) tick();
        chk("wrap_0", int'(instr), 0);
        chk("wrap_cyc", int'(cyc), 0);
        chk("wrap_en", int'(en), 5'h01);
        halt = 1'b1; tick(); halt = 1'b0;
        repeat (2) tick();
        chk("end_halted", int'(halted), 1);
        chk("end_instr", int'(instr), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
